// File: rtl/dma_controller_if.sv
// Configuration, arbitration and address/strobe signals of the DMA controller.
// The DMA engine uses the master modport. The CPU/arbiter/slave side uses the slave modport.
interface dma_controller_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        bus_req;
    logic        bus_grant;
    logic [31:0] address_Bus;
    logic        Read_DMA;
    logic        Write_DMA;
    logic        busy;
    logic        done;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, bus_grant,
        output bus_req, address_Bus, Read_DMA, Write_DMA, busy, done
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, bus_grant,
        input  bus_req, address_Bus, Read_DMA, Write_DMA, busy, done
    );
endinterface

// File: rtl/dma_controller.sv
// Single-channel block DMA controller.
// Each word is read from SRC in two cycles, buffered, and written to DST.
// Data_Bus stays a plain inout port, so the tri-state net resolves on one ordinary wire.
module dma_controller (
    input  logic              CLK,
    input  logic              RST_N,
    dma_controller_if.master  bus,
    inout  wire  [31:0]       Data_Bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD1,
        S_RD2,
        S_WR,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [1:0] ADDR_SRC   = 2'd0;
    localparam logic [1:0] ADDR_DST   = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] count_q, count_d;
    logic        src_inc_q, src_inc_d;
    logic        dst_inc_q, dst_inc_d;
    logic        abort_q, abort_d;
    logic [31:0] buffer_q, buffer_d;

    logic        cfg_idle_we;
    logic        start_req;
    logic        abort_req;
    logic        in_block;

    logic        bus_req_o;
    logic        read_o;
    logic        write_o;
    logic [31:0] addr_o;

    // Registers can be written only in IDLE. While a block is active, only the abort request is accepted.
    assign cfg_idle_we = bus.cfg_we && (state_q == S_IDLE);
    assign start_req   = cfg_idle_we && (bus.cfg_addr == ADDR_CTRL) && bus.cfg_wdata[0];
    assign in_block    = (state_q == S_REQ) || (state_q == S_RD1) || (state_q == S_RD2) ||
                         (state_q == S_WR)  || (state_q == S_NEXT);
    assign abort_req   = bus.cfg_we && in_block && (bus.cfg_addr == ADDR_CTRL) && bus.cfg_wdata[3];

    // State register. Reset immediately returns the engine to IDLE and abandons any word in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A loss of grant only takes effect at word boundaries (REQ and NEXT).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = (count_q != 16'd0) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (abort_q) begin
                    state_d = S_DONE;
                end else if (bus.bus_grant) begin
                    state_d = S_RD1;
                end
            end
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_WR;
            S_WR:   state_d = S_NEXT;
            S_NEXT: begin
                if ((count_q == 16'd1) || abort_q) begin
                    state_d = S_DONE;
                end else if (bus.bus_grant) begin
                    state_d = S_RD1;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode. Everything is a function of the state, so reset silences the bus immediately.
    always_comb begin
        bus_req_o = 1'b0;
        read_o    = 1'b0;
        write_o   = 1'b0;
        addr_o    = 32'd0;
        case (state_q)
            S_REQ:  bus_req_o = 1'b1;
            S_RD1, S_RD2: begin
                bus_req_o = 1'b1;
                read_o    = 1'b1;
                addr_o    = src_q;
            end
            S_WR: begin
                bus_req_o = 1'b1;
                write_o   = 1'b1;
                addr_o    = dst_q;
            end
            S_NEXT: bus_req_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.bus_req     = bus_req_o;
    assign bus.Read_DMA    = read_o;
    assign bus.Write_DMA   = write_o;
    assign bus.address_Bus = addr_o;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign Data_Bus        = write_o ? buffer_q : 32'bz;

    // Datapath next values: register programming, read-data capture, and pointer/count stepping.
    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        count_d   = count_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        abort_d   = abort_q;
        buffer_d  = buffer_q;

        if (cfg_idle_we) begin
            case (bus.cfg_addr)
                ADDR_SRC:   src_d   = bus.cfg_wdata;
                ADDR_DST:   dst_d   = bus.cfg_wdata;
                ADDR_COUNT: count_d = bus.cfg_wdata[15:0];
                ADDR_CTRL: begin
                    src_inc_d = bus.cfg_wdata[1];
                    dst_inc_d = bus.cfg_wdata[2];
                end
                default: ;
            endcase
        end

        if (state_q == S_RD2) begin
            buffer_d = Data_Bus;
        end

        if (state_q == S_NEXT) begin
            src_d   = src_q + {31'd0, src_inc_q};
            dst_d   = dst_q + {31'd0, dst_inc_q};
            count_d = count_q - 16'd1;
        end

        if (abort_req) begin
            abort_d = 1'b1;
        end
        if (state_q == S_DONE) begin
            abort_d = 1'b0;
        end
    end

    // Datapath registers. All are cleared by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            count_q   <= 16'd0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            abort_q   <= 1'b0;
            buffer_q  <= 32'd0;
        end else begin
            src_q     <= src_d;
            dst_q     <= dst_d;
            count_q   <= count_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            abort_q   <= abort_d;
            buffer_q  <= buffer_d;
        end
    end

endmodule
